addsub_response_checker: RTL and testbench
==========================================

Name: addsub_response_checker

Overview:
- Synthesizable stimulus-and-response checker for the adder_subtractor datapath; it is the receiving end of the exhaustive sweep.
- Drives every (m, a, b) combination into the DUT, samples sum/c_out/v after a settle window, and compares each against an internal golden model.
- Reports error count, first failing vector and pass/fail, for on-board self-test or as a bench-side scoreboard.

Parameters:
- WIDTH, 4, operand width of a, b, sum.
- SETTLE_CYCLES, 1, clock cycles (>=1) between driving a vector and sampling the DUT response.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  begin a sweep; sampled in IDLE or DONE only.
- dut_m  output  1  mode to DUT (0 = add, 1 = subtract).
- dut_a  output  WIDTH  operand a to DUT.
- dut_b  output  WIDTH  operand b to DUT.
- dut_sum  input  WIDTH  DUT result.
- dut_c_out  input  1  DUT carry out.
- dut_v  input  1  DUT signed overflow.
- busy  output  1  sweep in progress.
- done  output  1  sweep complete; held until next start or reset.
- pass  output  1  done && err_count == 0.
- err_count  output  2*WIDTH+2  number of mismatching vectors, saturating at all-ones.
- fail_valid  output  1  at least one mismatch recorded.
- fail_vec  output  2*WIDTH+1  first failing {m, a, b}.

Behaviour:
- Reset (rst_n = 0 at clk edge): state IDLE. All outputs 0. Index, settle counter, err_count and fail_vec cleared. Reset mid-sweep aborts the sweep immediately.
- Vector index: 2*WIDTH+1 bits, {m, a, b} with b as LSBs. Order is m outer, a middle, b inner: 0,0,0 -> 0,0,1 -> ... -> 1,15,15 at WIDTH = 4, giving 2^(2*WIDTH+1) vectors.
- dut_m/dut_a/dut_b are registered and equal the current index fields while busy. They hold the last vector in DONE and are 0 in IDLE.
- Golden model:
  - bb = b XOR {WIDTH{m}}.
  - {c_exp, sum_exp} = a + bb + m, computed WIDTH+1 bits wide.
  - v_exp = (a[MSB] == bb[MSB]) && (sum_exp[MSB] != a[MSB]).
  - In subtract mode c_out is the raw carry, so it is 1 when a >= b unsigned; b = 0 gives c = 1.
- A mismatch is any difference in sum, c_out or v; one mismatch counts once per vector.
- FSM:
  - IDLE: start=1 -> load index 0, settle count 0, clear err_count/fail_*, busy=1 -> WAIT.
  - WAIT: count settle cycles; after SETTLE_CYCLES cycles in WAIT -> CHECK.
  - CHECK (one cycle): compare DUT inputs against the golden model for the driven vector.
    - On mismatch: err_count++ (saturating). If fail_valid was 0, load fail_vec and set fail_valid=1.
    - Last index -> DONE (busy=0, done=1). Otherwise index++ -> WAIT.
  - DONE: start=1 -> same as from IDLE (clears done/pass/results, begins a new sweep).
- start while busy is ignored. start held high across DONE restarts the sweep once on each entry to DONE.
- Sweep length: start accepted at edge T gives done=1 after edge T + N*(SETTLE_CYCLES+1), where N = vector count. For WIDTH = 4 and SETTLE_CYCLES = 1 this is 1024 cycles.
- pass is combinational from done and err_count, registered-equivalent timing: high in the same cycle as done.

Optional Feature:
- Macro STOP_ON_FAIL_EN.
- Defined: on the first mismatch in CHECK, go directly to DONE with err_count = 1, fail_valid = 1, and fail_vec set to that vector. DUT drive holds the failing vector for debug.
- Undefined: the full sweep always runs and all mismatches are counted.

Test Plan:
- Correct behavioural adder_subtractor attached, WIDTH=4, SETTLE_CYCLES=1, start pulse -> busy for 1024 cycles, then done=1, pass=1, err_count=0, fail_valid=0.
- DUT with sum[0] stuck at 0 -> done after 1024 cycles, err_count=256, pass=0, fail_vec={0,0,1} (m=0, a=0, b=1).
- DUT with v inverted -> err_count=512, fail_vec={0,0,0}. DUT with c_out forced 0 only in subtract mode -> err_count=136 (vectors with a>=b), fail_vec={1,0,0}.
- rst_n=0 for one cycle at cycle 300 of a sweep -> next cycle all outputs 0, state IDLE. A new start yields a full, correct 1024-cycle sweep.
- start pulsed at cycle 10 and cycle 500 of a sweep -> ignored, done still at cycle 1024. start in DONE -> done/pass drop the next cycle and a new sweep begins.
- STOP_ON_FAIL_EN defined, sum[0] stuck-at-0 DUT -> done after 4 cycles (index 1 CHECK), err_count=1, fail_vec={0,0,1}, dut_b holds 1.

Source files
------------

// File: rtl/addsub_response_checker_if.sv
// addsub_response_checker_if: stimulus/response bus between checker (master) and adder_subtractor (slave)
interface addsub_response_checker_if #(
  parameter int WIDTH = 4
);
  logic             m;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             v;
  modport master (output m, a, b, input sum, c_out, v);
  modport slave (input m, a, b, output sum, c_out, v);
endinterface

// File: rtl/addsub_response_checker.sv
// addsub_response_checker: exhaustive sweep and golden compare of an adder_subtractor; STOP_ON_FAIL_EN halts on first mismatch
module addsub_response_checker #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  addsub_response_checker_if.master bus,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [2*WIDTH+1:0]       err_count,
  output logic                     fail_valid,
  output logic [2*WIDTH:0]         fail_vec
);
  localparam int IW = 2*WIDTH+1;
  localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] bb, sum_exp;
  logic c_exp, v_exp, mismatch, launch, settled, last, stop;
  assign bus.m = idx[IW-1];
  assign bus.a = idx[2*WIDTH-1:WIDTH];
  assign bus.b = idx[WIDTH-1:0];
  assign bb = bus.b ^ {WIDTH{bus.m}};
  assign {c_exp, sum_exp} = {1'b0, bus.a} + {1'b0, bb} + {{WIDTH{1'b0}}, bus.m};
  assign v_exp = (bus.a[WIDTH-1] == bb[WIDTH-1]) && (sum_exp[WIDTH-1] != bus.a[WIDTH-1]);
  assign mismatch = (bus.sum != sum_exp) || (bus.c_out != c_exp) || (bus.v != v_exp);
  assign launch = start && (state == S_IDLE || state == S_DONE);
  assign settled = cnt == CW'(SETTLE_CYCLES-1);
  assign last = &idx;
`ifdef STOP_ON_FAIL_EN
  assign stop = mismatch;
`else
  assign stop = 1'b0;
`endif
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? S_IDLE : state_n;
  // next-state: settle in WAIT, one compare cycle in CHECK, restart only from IDLE/DONE
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  state_n = start ? S_WAIT : S_IDLE;
      S_WAIT:  state_n = settled ? S_CHECK : S_WAIT;
      S_CHECK: state_n = (last || stop) ? S_DONE : S_WAIT;
      S_DONE:  state_n = start ? S_WAIT : S_DONE;
      default: state_n = S_IDLE;
    endcase
  end
  // outputs decoded from the state register
  always_comb begin
    busy = state == S_WAIT || state == S_CHECK;
    done = state == S_DONE;
    pass = done && err_count == '0;
  end
  // sweep index, settle counter and result capture; idx doubles as the DUT drive
  always_ff @(posedge clk) begin
    if (!rst_n || launch) begin
      idx        <= '0;
      cnt        <= '0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_vec   <= '0;
    end else if (state == S_WAIT) begin
      cnt <= settled ? '0 : cnt + 1'b1;
    end else if (state == S_CHECK) begin
      if (mismatch) begin
        err_count <= &err_count ? err_count : err_count + 1'b1;
        if (!fail_valid) begin
          fail_valid <= 1'b1;
          fail_vec   <= idx;
        end
      end
      if (state_n == S_WAIT) idx <= idx + 1'b1;
    end
  end
endmodule

// File: tb/tb_addsub_response_checker.sv
// tb_addsub_response_checker: directed fault-injection vectors against the response checker
module tb_addsub_response_checker;
  logic clk = 0, rst_n = 0, start = 0;
  logic busy, done, pass, fail_valid;
  logic [9:0] err_count;
  logic [8:0] fail_vec;
  int fault = 0, checks = 0, errors = 0;
  addsub_response_checker_if #(.WIDTH(4)) bus ();
  addsub_response_checker #(.WIDTH(4), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_vec(fail_vec)
  );
  always #5 clk = ~clk;
  logic [3:0] bb, s;
  logic c, vv;
  // behavioural adder_subtractor with selectable planted faults
  always_comb begin
    bb = bus.b ^ {4{bus.m}};
    {c, s} = {1'b0, bus.a} + {1'b0, bb} + {4'b0, bus.m};
    vv = (bus.a[3] == bb[3]) && (s[3] != bus.a[3]);
    bus.sum = fault == 1 ? {s[3:1], 1'b0} : s;
    bus.c_out = (fault == 3 && bus.m) ? 1'b0 : c;
    bus.v = fault == 2 ? ~vv : vv;
  end
  typedef struct {
    int fault; int cyc; int err; int fv; int vec; int ps; int drv;
  } vec_t;
  vec_t tbl[4];
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic check_zero(input string tag);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " pass"}, pass, 0);
    chk({tag, " err_count"}, err_count, 0);
    chk({tag, " fail_valid"}, fail_valid, 0);
    chk({tag, " fail_vec"}, fail_vec, 0);
    chk({tag, " drive"}, {bus.m, bus.a, bus.b}, 0);
  endtask
  task automatic sweep(input int p1, input int p2, output int cycles);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    chk("busy after start", busy, 1);
    cycles = 0;
    while (!done && cycles < 3000) begin
      start = (cycles == p1 || cycles == p2);
      @(posedge clk); #1;
      cycles++;
    end
    start = 0;
    if (!done) chk("sweep timeout", cycles, -1);
  endtask
  initial begin
    int cyc;
    tbl[0] = '{0, 1024, 0, 0, 0, 1, 9'h1ff};
`ifdef STOP_ON_FAIL_EN
    tbl[1] = '{1, 4, 1, 1, 9'h001, 0, 9'h001};
    tbl[2] = '{2, 2, 1, 1, 9'h000, 0, 9'h000};
    tbl[3] = '{3, 514, 1, 1, 9'h100, 0, 9'h100};
`else
    tbl[1] = '{1, 1024, 256, 1, 9'h001, 0, 9'h1ff};
    tbl[2] = '{2, 1024, 512, 1, 9'h000, 0, 9'h1ff};
    tbl[3] = '{3, 1024, 136, 1, 9'h100, 0, 9'h1ff};
`endif
    repeat (2) @(posedge clk);
    #1 check_zero("reset");
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      fault = tbl[i].fault;
      sweep(-1, -1, cyc);
      chk($sformatf("v%0d cycles", i), cyc, tbl[i].cyc);
      chk($sformatf("v%0d err_count", i), err_count, tbl[i].err);
      chk($sformatf("v%0d fail_valid", i), fail_valid, tbl[i].fv);
      chk($sformatf("v%0d fail_vec", i), fail_vec, tbl[i].vec);
      chk($sformatf("v%0d pass", i), pass, tbl[i].ps);
      chk($sformatf("v%0d busy", i), busy, 0);
      chk($sformatf("v%0d drive", i), {bus.m, bus.a, bus.b}, tbl[i].drv);
    end
    fault = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    repeat (300) @(posedge clk);
    #1 rst_n = 0;
    @(posedge clk); #1 check_zero("mid reset");
    rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("idle stays idle", busy, 0);
    sweep(9, 499, cyc);
    chk("ignored start cycles", cyc, 1024);
    chk("ignored start pass", pass, 1);
    chk("ignored start err", err_count, 0);
    start = 1;
    @(posedge clk); #1 start = 0;
    chk("restart done", done, 0);
    chk("restart pass", pass, 0);
    chk("restart busy", busy, 1);
    chk("restart drive", {bus.m, bus.a, bus.b}, 0);
    cyc = 0;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("restart cycles", cyc, 1024);
    chk("restart final pass", pass, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
